frame_counter: RTL and testbench

- Parametrised successor to the single-mode up-counter.
- Counts 0..NUM with:
  - a clock-enable prescaler
  - up/down direction
  - wrap or saturate mode
  - synchronous clear and load
  - terminal-count pulse
  - an epoch counter of completed wraps
- Acts as the frame/bit-position timer for the convolutional encoder/decoder datapath, replacing fixed-length free-running counters.

---
 rtl/frame_counter_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 41 ++++
 rtl/frame_counter.sv | 115 +++++++++++
 tb/tb_frame_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_counter_pkg.sv
// Shared encodings and parameter legality helpers for the frame/bit-position timers.
package frame_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // NUM must be a nonzero value representable in LEN bits.
    function automatic bit num_legal(input int unsigned len, input int unsigned num);
        return (len >= 1) && (len <= 32) && (num >= 1) && (64'(num) < (64'd1 << len));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one tick every DIV enabled clocks, phase held while disabled.
module tick_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_sig,
    input  logic reset_sig,
    input  logic en_sig,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $fatal(1, "tick_prescaler: DIV must be at least 1");
    end

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en_sig && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en_sig) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_counter.sv
// Up/down frame counter over 0..NUM with wrap/saturate, prescaled stepping,
// terminal-count pulse and a count of completed wraps.
module frame_counter
    import frame_counter_pkg::*;
#(
    parameter int unsigned LEN       = 11,
    parameter int unsigned NUM       = 2047,
    parameter int unsigned DIV       = 1,
    parameter int unsigned EPOCH_LEN = 8
) (
    input  logic                 clk_sig,
    input  logic                 reset_sig,
    input  logic                 en_sig,
    input  logic                 clr_sig,
    input  logic                 load_sig,
    input  logic [LEN-1:0]       load_val_sig,
    input  logic                 dir_sig,
    input  logic                 sat_sig,
    output logic [LEN-1:0]       counter_sig,
    output logic                 tc_sig,
    output logic                 sat_flag_sig,
    output logic [EPOCH_LEN-1:0] epoch_sig
);

    localparam bit NUM_LEGAL = num_legal(LEN, NUM);
    localparam logic [LEN-1:0] NUM_V = LEN'(NUM);

    if (!NUM_LEGAL) begin : g_bad_num
        $fatal(1, "frame_counter: NUM must lie in 1..2^LEN-1");
    end

    logic [LEN-1:0]       counter_q, counter_d;
    logic [EPOCH_LEN-1:0] epoch_q, epoch_d;
    logic                 tc_q, tc_d;
    logic                 sat_flag_q, sat_flag_d;
    logic                 tick;
    logic [LEN-1:0]       load_clamped;

    // Clear and load both restart the prescale phase.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .en_sig    (en_sig),
        .sync_clr  (clr_sig | load_sig),
        .tick      (tick)
    );

    assign load_clamped = (load_val_sig > NUM_V) ? NUM_V : load_val_sig;

    always_comb begin
        counter_d  = counter_q;
        epoch_d    = epoch_q;
        sat_flag_d = sat_flag_q;
        tc_d       = 1'b0;
        if (clr_sig) begin
            counter_d  = '0;
            epoch_d    = '0;
            sat_flag_d = 1'b0;
        end else if (load_sig) begin
            counter_d = load_clamped;
        end else if (tick) begin
            case (dir_sig)
                DIR_UP: begin
                    if (counter_q != NUM_V) begin
                        counter_d = counter_q + LEN'(1);
                        tc_d      = (counter_d == NUM_V);
                    end else if (sat_sig == MODE_WRAP) begin
                        counter_d = '0;
                        epoch_d   = epoch_q + EPOCH_LEN'(1);
                        tc_d      = 1'b1;
                    end else begin
                        sat_flag_d = 1'b1;
                        tc_d       = 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (counter_q != '0) begin
                        counter_d = counter_q - LEN'(1);
                        tc_d      = (counter_d == '0);
                    end else if (sat_sig == MODE_WRAP) begin
                        counter_d = NUM_V;
                        epoch_d   = epoch_q + EPOCH_LEN'(1);
                        tc_d      = 1'b1;
                    end else begin
                        sat_flag_d = 1'b1;
                        tc_d       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            counter_q  <= '0;
            epoch_q    <= '0;
            tc_q       <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            epoch_q    <= epoch_d;
            tc_q       <= tc_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign counter_sig  = counter_q;
    assign tc_sig       = tc_q;
    assign sat_flag_sig = sat_flag_q;
    assign epoch_sig    = epoch_q;

endmodule

// File: tb/tb_frame_counter.sv
// Bench for frame_counter: two instances (DIV=1, DIV=3) on shared stimulus against a
// modular-arithmetic reference model, plus directed constant checks.
module tb_frame_counter;

    localparam int NUM = 10;

    logic       clk = 1'b0;
    logic       reset_sig = 1'b0;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0, sat = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] c0, c1;
    logic       tc0, tc1, sf0, sf1;
    logic [7:0] e0, e1;

    int n_checks = 0;
    int n_fail   = 0;

    int divs[2] = '{1, 3};
    int m_cnt[2], m_pre[2], m_ep[2];
    bit m_tc[2], m_sf[2];

    always #5 clk = ~clk;

    frame_counter #(.LEN(4), .NUM(NUM), .DIV(1), .EPOCH_LEN(8)) dut0 (
        .clk_sig (clk), .reset_sig (reset_sig), .en_sig (en), .clr_sig (clr),
        .load_sig (load), .load_val_sig (load_val), .dir_sig (dir), .sat_sig (sat),
        .counter_sig (c0), .tc_sig (tc0), .sat_flag_sig (sf0), .epoch_sig (e0)
    );

    frame_counter #(.LEN(4), .NUM(NUM), .DIV(3), .EPOCH_LEN(8)) dut1 (
        .clk_sig (clk), .reset_sig (reset_sig), .en_sig (en), .clr_sig (clr),
        .load_sig (load), .load_val_sig (load_val), .dir_sig (dir), .sat_sig (sat),
        .counter_sig (c1), .tc_sig (tc1), .sat_flag_sig (sf1), .epoch_sig (e1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_ep[i] = 0; m_tc[i] = 0; m_sf[i] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, with wrap expressed modulo NUM+1.
    task automatic model_edge();
        int raw, nxt;
        bit wrapped, blocked;
        for (int i = 0; i < 2; i++) begin
            if (reset_sig || clr) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_ep[i] = 0; m_tc[i] = 0; m_sf[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) > NUM) ? NUM : int'(load_val);
                m_pre[i] = 0;
                m_tc[i]  = 0;
            end else if (en) begin
                m_tc[i] = 0;
                m_pre[i]++;
                if (m_pre[i] == divs[i]) begin
                    m_pre[i] = 0;
                    raw = m_cnt[i] + (dir ? -1 : 1);
                    wrapped = 0;
                    blocked = 0;
                    if (sat) begin
                        nxt = (raw < 0) ? 0 : (raw > NUM) ? NUM : raw;
                        blocked = (nxt == m_cnt[i]);
                        if (blocked) m_sf[i] = 1;
                    end else begin
                        nxt = (raw + NUM + 1) % (NUM + 1);
                        wrapped = (raw < 0) || (raw > NUM);
                        if (wrapped) m_ep[i] = (m_ep[i] + 1) % 256;
                    end
                    m_tc[i]  = blocked || wrapped || (nxt == (dir ? 0 : NUM));
                    m_cnt[i] = nxt;
                end
            end else begin
                m_tc[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("d1_cnt", 32'(c0), 32'(m_cnt[0]));
        chk("d1_tc", 32'(tc0), 32'(m_tc[0]));
        chk("d1_sat_flag", 32'(sf0), 32'(m_sf[0]));
        chk("d1_epoch", 32'(e0), 32'(m_ep[0]));
        chk("d3_cnt", 32'(c1), 32'(m_cnt[1]));
        chk("d3_tc", 32'(tc1), 32'(m_tc[1]));
        chk("d3_sat_flag", 32'(sf1), 32'(m_sf[1]));
        chk("d3_epoch", 32'(e1), 32'(m_ep[1]));
    endtask

    // Inputs are changed 1 time unit after an edge; outputs are sampled likewise.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic e, input logic c, input logic l, input logic [3:0] v,
                          input logic d, input logic s);
        en = e; clr = c; load = l; load_val = v; dir = d; sat = s;
    endtask

    int exp_c[5]  = '{1, 0, 0, 0, 0};
    int exp_tc[5] = '{0, 1, 1, 1, 1};
    int exp_sf[5] = '{0, 0, 1, 1, 1};
    int ep_before;

    initial begin
        // Asynchronous reset from time zero, held for two edges.
        #1 reset_sig = 1'b1;
        #1;
        model_reset();
        check_all();
        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        reset_sig = 1'b0;

        // Wrap-up counting on both prescale ratios.
        for (int k = 1; k <= 33; k++) begin
            cyc();
            if (k == 10) begin
                chk("wrap_up_top_cnt", 32'(c0), 32'd10);
                chk("wrap_up_top_tc", 32'(tc0), 32'd1);
            end
            if (k == 11) begin
                chk("wrap_up_wrap_cnt", 32'(c0), 32'd0);
                chk("wrap_up_wrap_tc", 32'(tc0), 32'd1);
                chk("wrap_up_epoch", 32'(e0), 32'd1);
            end
        end
        chk("d3_wrap_cnt", 32'(c1), 32'd0);
        chk("d3_wrap_epoch", 32'(e1), 32'd1);
        chk("d1_three_wraps", 32'(e0), 32'd3);

        // Enable drop mid-prescale keeps the partial phase.
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        chk("d3_hold_cnt", 32'(c1), 32'd1);
        en = 1'b1;
        cyc();
        chk("d3_resume1_cnt", 32'(c1), 32'd1);
        cyc();
        chk("d3_resume2_cnt", 32'(c1), 32'd2);

        // Down count into a saturated bound.
        set_in(1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
        cyc();
        chk("sat_load_cnt", 32'(c0), 32'd2);
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("sat_seq_cnt", 32'(c0), 32'(exp_c[k]));
            chk("sat_seq_tc", 32'(tc0), 32'(exp_tc[k]));
            chk("sat_seq_flag", 32'(sf0), 32'(exp_sf[k]));
        end
        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc();
        chk("sat_flag_sticky", 32'(sf0), 32'd1);
        clr = 1'b1;
        cyc();
        chk("sat_flag_cleared", 32'(sf0), 32'd0);

        // Load clamp, then clear beating load.
        set_in(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        cyc();
        chk("clamp_d1", 32'(c0), 32'd10);
        chk("clamp_d3", 32'(c1), 32'd10);
        load = 1'b0;
        cyc();
        chk("pre_clr_epoch", 32'(e0), 32'd1);
        clr = 1'b1; load = 1'b1; load_val = 4'd5;
        cyc();
        chk("clr_over_load_cnt", 32'(c0), 32'd0);
        chk("clr_over_load_epoch", 32'(e0), 32'd0);

        // Direction flip at the top bound, then down-wrap.
        set_in(1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        cyc();
        ep_before = int'(e0);
        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc();
        chk("flip_cnt", 32'(c0), 32'd9);
        chk("flip_tc", 32'(tc0), 32'd0);
        chk("flip_epoch", 32'(e0), 32'(ep_before));
        set_in(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        cyc();
        load = 1'b0;
        cyc();
        chk("down_wrap_cnt", 32'(c0), 32'd10);
        chk("down_wrap_tc", 32'(tc0), 32'd1);
        chk("down_wrap_epoch", 32'(e0), 32'((ep_before + 1) % 256));

        // Reach counter=7, epoch=3, then reset between edges.
        set_in(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc();
        clr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            load = 1'b1; load_val = 4'd10;
            cyc();
            load = 1'b0;
            cyc();
        end
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        cyc();
        load = 1'b0;
        chk("pre_reset_cnt", 32'(c0), 32'd7);
        chk("pre_reset_epoch", 32'(e0), 32'd3);
        #3 reset_sig = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset_sig = 1'b0;

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            sat      = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
